// File: rtl/rtc_access_sched.sv
// RTC access scheduler: arbitrates host writes, host reads and periodic
// polls onto a single RTC driver read/write handshake.
module rtc_access_sched #(
  parameter int          POLL_CYCLES    = 50_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [55:0] DEFAULT_TIME   = 56'h16_02_12_13_13_10_01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_wr_req,
  input  logic [55:0] host_wr_time,
  output logic        host_wr_ack,
  input  logic        host_rd_req,
  output logic        host_rd_ack,
  output logic [55:0] time_out,
  output logic        time_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        drv_wr_req,
  input  logic        drv_wr_ack,
  output logic [55:0] drv_wr_time,
  output logic        drv_rd_req,
  input  logic        drv_rd_ack,
  input  logic [55:0] drv_rd_time
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  // Bit 7 of the seconds byte is the RTC clock-halt flag.
  localparam logic [55:0] HALT_BIT  = 56'h80;

  typedef enum logic [2:0] {
    S_BOOT_RD,
    S_BOOT_WR,
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t        state_q;
  logic [PW-1:0] poll_cnt_q;
  logic [PW-1:0] poll_cnt_d;
  logic          poll_wrap;
  logic          poll_pending_q;
  logic [TW-1:0] to_cnt_q;
  logic          to_hit;
  logic          rd_host_q;
  logic          host_wr_ack_q;
  logic          host_rd_ack_q;
  logic [55:0]   time_out_q;
  logic          time_valid_q;
  logic          timeout_err_q;
  logic          drv_wr_req_q;
  logic          drv_rd_req_q;
  logic [55:0]   drv_wr_time_q;

  always_comb begin
    poll_wrap  = (poll_cnt_q == POLL_LAST);
    poll_cnt_d = poll_wrap ? '0 : poll_cnt_q + 1'b1;
    to_hit     = (to_cnt_q == TO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_BOOT_RD;
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      to_cnt_q       <= '0;
      rd_host_q      <= 1'b0;
      host_wr_ack_q  <= 1'b0;
      host_rd_ack_q  <= 1'b0;
      time_out_q     <= '0;
      time_valid_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      drv_wr_req_q   <= 1'b0;
      drv_rd_req_q   <= 1'b0;
      drv_wr_time_q  <= '0;
    end else begin
      host_wr_ack_q <= 1'b0;
      host_rd_ack_q <= 1'b0;
      poll_cnt_q    <= poll_cnt_d;
      if (poll_wrap) poll_pending_q <= 1'b1;
      unique case (state_q)
        S_BOOT_RD: begin
          if (!drv_rd_req_q) begin
            drv_rd_req_q <= 1'b1;
            to_cnt_q     <= '0;
          end else if (drv_rd_ack) begin
            drv_rd_req_q <= 1'b0;
            to_cnt_q     <= '0;
            if (drv_rd_time[7]) begin
              state_q       <= S_BOOT_WR;
              drv_wr_req_q  <= 1'b1;
              drv_wr_time_q <= DEFAULT_TIME & ~HALT_BIT;
            end else begin
              state_q      <= S_IDLE;
              time_out_q   <= drv_rd_time;
              time_valid_q <= 1'b1;
            end
          end else if (to_hit) begin
            drv_rd_req_q  <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_BOOT_WR: begin
          if (drv_wr_ack) begin
            drv_wr_req_q   <= 1'b0;
            state_q        <= S_RD;
            drv_rd_req_q   <= 1'b1;
            rd_host_q      <= 1'b0;
            poll_pending_q <= 1'b0;
            to_cnt_q       <= '0;
          end else if (to_hit) begin
            drv_wr_req_q  <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          to_cnt_q <= '0;
          if (host_wr_req) begin
            state_q       <= S_WR;
            drv_wr_req_q  <= 1'b1;
            drv_wr_time_q <= host_wr_time & ~HALT_BIT;
          end else if (host_rd_req || poll_pending_q) begin
            state_q        <= S_RD;
            drv_rd_req_q   <= 1'b1;
            rd_host_q      <= host_rd_req;
            poll_pending_q <= 1'b0;
          end
        end
        S_WR: begin
          if (drv_wr_ack) begin
            drv_wr_req_q   <= 1'b0;
            host_wr_ack_q  <= 1'b1;
            state_q        <= S_RD;
            drv_rd_req_q   <= 1'b1;
            rd_host_q      <= 1'b0;
            poll_pending_q <= 1'b0;
            to_cnt_q       <= '0;
          end else if (to_hit) begin
            drv_wr_req_q  <= 1'b0;
            host_wr_ack_q <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RD: begin
          if (drv_rd_ack) begin
            drv_rd_req_q  <= 1'b0;
            time_out_q    <= drv_rd_time;
            time_valid_q  <= 1'b1;
            host_rd_ack_q <= rd_host_q;
            state_q       <= S_IDLE;
          end else if (to_hit) begin
            drv_rd_req_q  <= 1'b0;
            host_rd_ack_q <= rd_host_q;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host_wr_ack = host_wr_ack_q;
  assign host_rd_ack = host_rd_ack_q;
  assign time_out    = time_out_q;
  assign time_valid  = time_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign drv_wr_req  = drv_wr_req_q;
  assign drv_wr_time = drv_wr_time_q;
  assign drv_rd_req  = drv_rd_req_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Directed bench for rtc_access_sched with a time scoreboard.
module tb_rtc_access_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_wr_req = 1'b0;
  logic [55:0] host_wr_time = '0;
  logic        host_wr_ack;
  logic        host_rd_req = 1'b0;
  logic        host_rd_ack;
  logic [55:0] time_out;
  logic        time_valid;
  logic        busy;
  logic        timeout_err;
  logic        drv_wr_req;
  logic        drv_wr_ack = 1'b0;
  logic [55:0] drv_wr_time;
  logic        drv_rd_req;
  logic        drv_rd_ack = 1'b0;
  logic [55:0] drv_rd_time = '0;

  int checks = 0;
  int failures = 0;
  logic [55:0] exp_time_q[$];
  logic [55:0] exp_wr_q[$];

  rtc_access_sched #(
    .POLL_CYCLES(100),
    .TIMEOUT_CYCLES(50),
    .DEFAULT_TIME(56'h16_02_12_13_13_10_01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_wr_req(host_wr_req),
    .host_wr_time(host_wr_time),
    .host_wr_ack(host_wr_ack),
    .host_rd_req(host_rd_req),
    .host_rd_ack(host_rd_ack),
    .time_out(time_out),
    .time_valid(time_valid),
    .busy(busy),
    .timeout_err(timeout_err),
    .drv_wr_req(drv_wr_req),
    .drv_wr_ack(drv_wr_ack),
    .drv_wr_time(drv_wr_time),
    .drv_rd_req(drv_rd_req),
    .drv_rd_ack(drv_rd_ack),
    .drv_rd_time(drv_rd_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    host_wr_req = 1'b0;
    host_rd_req = 1'b0;
    drv_wr_ack = 1'b0;
    drv_rd_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd_respond(input string tag, input logic [55:0] t,
                            input bit push, output logic hack);
    for (int i = 0; i < 60 && drv_rd_req !== 1'b1; i++) @(negedge clk);
    chk({tag, "_rd_req"}, drv_rd_req, 1);
    drv_rd_time = t;
    drv_rd_ack = 1'b1;
    if (push) exp_time_q.push_back(t);
    @(negedge clk);
    drv_rd_ack = 1'b0;
    hack = host_rd_ack;
    chk({tag, "_rd_req_drop"}, drv_rd_req, 0);
  endtask

  task automatic wr_respond(input string tag, output logic hack);
    logic [55:0] exp;
    for (int i = 0; i < 60 && drv_wr_req !== 1'b1; i++) @(negedge clk);
    chk({tag, "_wr_req"}, drv_wr_req, 1);
    exp = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 56'hx;
    chk({tag, "_wr_time"}, drv_wr_time, exp);
    drv_wr_ack = 1'b1;
    @(negedge clk);
    drv_wr_ack = 1'b0;
    hack = host_wr_ack;
    chk({tag, "_wr_req_drop"}, drv_wr_req, 0);
    chk({tag, "_readback_req"}, drv_rd_req, 1);
  endtask

  function automatic logic [55:0] pop_time();
    return (exp_time_q.size() > 0) ? exp_time_q.pop_front() : 56'hx;
  endfunction

  initial begin
    logic hack;
    int   cnt;
    int   rises[$];
    int   hra_seen;
    bit   ack_prev;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_flags",
        {busy, drv_rd_req, drv_wr_req, time_valid,
         timeout_err, host_wr_ack, host_rd_ack}, 64'h40);
    chk("rst_time_out", time_out, 0);
    chk("rst_drv_wr_time", drv_wr_time, 0);
    rst = 1'b0;

    // Normal boot, clock running
    rd_respond("boot_ok", 56'h24_05_06_15_09_30_45, 1, hack);
    chk("boot_ok_no_hrack", hack, 0);
    chk("boot_ok_no_wr", drv_wr_req, 0);
    chk("boot_ok_time", time_out, pop_time());
    chk("boot_ok_valid", time_valid, 1);
    chk("boot_ok_busy", busy, 0);

    // Boot with clock halted
    do_reset();
    exp_wr_q.push_back(56'h16_02_12_13_13_10_01);
    rd_respond("boot_halt", 56'h00_00_00_00_00_00_80, 0, hack);
    chk("halt_busy", busy, 1);
    chk("halt_valid0", time_valid, 0);
    wr_respond("boot_wr", hack);
    chk("boot_wr_no_hwack", hack, 0);
    rd_respond("boot_rb", 56'h16_02_12_13_13_10_05, 1, hack);
    chk("boot_rb_no_hrack", hack, 0);
    chk("boot_rb_time", time_out, pop_time());
    chk("boot_rb_valid", time_valid, 1);

    // Simultaneous host write and read
    host_wr_time = 56'h24_01_02_03_04_05_C5;
    host_wr_req = 1'b1;
    host_rd_req = 1'b1;
    exp_wr_q.push_back(56'h24_01_02_03_04_05_45);
    wr_respond("host_wr", hack);
    chk("host_wr_ack", hack, 1);
    host_wr_req = 1'b0;
    rd_respond("auto_rb", 56'h24_01_02_03_04_05_46, 1, hack);
    chk("auto_rb_no_hrack", hack, 0);
    chk("auto_rb_time", time_out, pop_time());
    chk("auto_rb_idle", busy, 0);
    rd_respond("host_rd", 56'h24_01_02_03_04_05_47, 1, hack);
    chk("host_rd_ack", hack, 1);
    host_rd_req = 1'b0;
    chk("host_rd_time", time_out, pop_time());
    @(negedge clk);
    chk("host_rd_ack_pulse", host_rd_ack, 0);
    chk("host_rd_idle", busy, 0);

    // Reset during a write
    do_reset();
    rd_respond("e_boot", 56'h23_01_01_01_01_01_01, 1, hack);
    chk("e_boot_time", time_out, pop_time());
    host_wr_time = 56'h23_02_02_02_02_02_02;
    host_wr_req = 1'b1;
    for (int i = 0; i < 20 && drv_wr_req !== 1'b1; i++) @(negedge clk);
    chk("e_wr_req", drv_wr_req, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("e_async_wr_req", drv_wr_req, 0);
    chk("e_async_busy", busy, 1);
    chk("e_async_time_out", time_out, 0);
    host_wr_req = 1'b0;
    @(negedge clk);
    chk("e_no_hwack_rst", host_wr_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("e_boot_restart", drv_rd_req, 1);
    chk("e_no_hwack_after", host_wr_ack, 0);
    rd_respond("e_reboot", 56'h23_03_03_03_03_03_03, 1, hack);
    chk("e_reboot_time", time_out, pop_time());

    // Boot read never acknowledged
    do_reset();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drv_rd_req) cnt++;
      else if (cnt > 0) break;
    end
    chk("to_req_cycles", cnt, 50);
    chk("to_err", timeout_err, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", time_valid, 0);
    chk("to_time", time_out, 0);
    drv_rd_time = 56'h11_11_11_11_11_11_11;
    drv_rd_ack = 1'b1;
    @(negedge clk);
    drv_rd_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_time", time_out, 0);
    chk("stray_ack_busy", busy, 0);

    // Host read that times out
    do_reset();
    rd_respond("h_boot", 56'h22_02_03_04_05_06_07, 1, hack);
    chk("h_boot_time", time_out, pop_time());
    chk("h_err0", timeout_err, 0);
    host_rd_req = 1'b1;
    for (int i = 0; i < 120 && host_rd_ack !== 1'b1; i++) @(negedge clk);
    chk("h_to_hrack", host_rd_ack, 1);
    host_rd_req = 1'b0;
    chk("h_to_err", timeout_err, 1);
    chk("h_to_time", time_out, 56'h22_02_03_04_05_06_07);
    chk("h_to_valid", time_valid, 1);
    @(negedge clk);
    chk("h_to_idle", busy, 0);

    // Periodic polling
    do_reset();
    rd_respond("p_boot", 56'h21_00_00_00_00_00_00, 1, hack);
    chk("p_boot_time", time_out, pop_time());
    hra_seen = 0;
    ack_prev = 1'b0;
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      drv_rd_ack = 1'b0;
      if (host_rd_ack) hra_seen++;
      if (ack_prev) chk("poll_time", time_out, pop_time());
      ack_prev = 1'b0;
      if (drv_rd_req) begin
        rises.push_back(i);
        drv_rd_time = 56'h21_00_00_00_00_00_10 + 56'(rises.size());
        exp_time_q.push_back(drv_rd_time);
        drv_rd_ack = 1'b1;
        ack_prev = 1'b1;
      end
    end
    @(negedge clk);
    drv_rd_ack = 1'b0;
    if (ack_prev) chk("poll_time_last", time_out, pop_time());
    chk("poll_count", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("poll_gap1", rises[1] - rises[0], 100);
      chk("poll_gap2", rises[2] - rises[1], 100);
    end
    chk("poll_no_hrack", hra_seen, 0);
    chk("poll_no_err", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_access_sched.md
RTC_ACCESS_SCHED -- requirements
Module: rtc_access_sched

Interface
Parameters:
REQ-001 SHALL provide POLL_CYCLES, default 50_000_000, clk cycles between automatic time reads.
REQ-002 SHALL provide TIMEOUT_CYCLES, default 1_000_000, maximum cycles to wait for a driver ack.
REQ-003 SHALL provide DEFAULT_TIME, 56 bits, default 56'h16_02_12_13_13_10_01, time written when the clock-halt bit is found set.

Ports (name  direction  width  meaning). All time buses are {year,week,month,date,hour,minute,second} in BCD, second in [7:0].
REQ-004 SHALL have clk  input  1  system clock.
REQ-005 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have host_wr_req  input  1  level; host requests a time write.
REQ-007 SHALL have host_wr_time  input  56  time to write; sampled at grant.
REQ-008 SHALL have host_wr_ack  output  1  one-cycle pulse; host write finished.
REQ-009 SHALL have host_rd_req  input  1  level; host requests a fresh read.
REQ-010 SHALL have host_rd_ack  output  1  one-cycle pulse; time_out updated for host.
REQ-011 SHALL have time_out  output  56  last successfully read time.
REQ-012 SHALL have time_valid  output  1  time_out holds at least one successful read.
REQ-013 SHALL have busy  output  1  high in every state except S_IDLE.
REQ-014 SHALL have timeout_err  output  1  sticky; a driver transaction timed out.
REQ-015 SHALL have drv_wr_req / drv_wr_ack / drv_wr_time  out/in/out  1/1/56  driver write handshake.
REQ-016 SHALL have drv_rd_req / drv_rd_ack / drv_rd_time  out/in/in  1/1/56  driver read handshake.

Function
REQ-017 SHALL implement states S_BOOT_RD, S_BOOT_WR, S_IDLE, S_WR, S_RD.
REQ-018 SHALL leave reset in S_BOOT_RD, asserting drv_rd_req.
REQ-019 S_BOOT_RD on drv_rd_ack: drv_rd_time[7]=1 (clock halted) -> S_BOOT_WR; else capture time_out, set time_valid, -> S_IDLE.
REQ-020 S_BOOT_WR SHALL drive drv_wr_time=DEFAULT_TIME with bit 7 of second forced 0; on drv_wr_ack -> S_RD.
REQ-021 S_IDLE grant priority, evaluated each cycle: host_wr_req > host_rd_req > poll_pending; none -> stay.
REQ-022 Host write grant SHALL latch host_wr_time (second[7] forced 0) into drv_wr_time, enter S_WR.
REQ-023 S_WR on drv_wr_ack: pulse host_wr_ack next cycle, -> S_RD (automatic readback, not host-owned).
REQ-024 S_RD on drv_rd_ack: register drv_rd_time into time_out, set time_valid, pulse host_rd_ack only if the read was granted to host_rd_req, -> S_IDLE.
REQ-025 drv_*_req SHALL be registered, high from state entry until the cycle after the matching ack, never both high.
REQ-026 Entering S_RD from any path SHALL clear poll_pending.
REQ-027 Poll counter SHALL run in every state, wrap at POLL_CYCLES-1, and set poll_pending on wrap; an unserviced wrap does not queue a second read.
REQ-028 Timeout counter SHALL clear on state entry, count while a drv_*_req is high; reaching TIMEOUT_CYCLES-1 drops the request, sets timeout_err, -> S_IDLE.
REQ-029 On timeout the owning host ack (host_wr_ack or host_rd_ack) SHALL still pulse; time_out and time_valid SHALL be unchanged.
REQ-030 Host requests arriving while busy SHALL be held by the host and granted on the next S_IDLE cycle.
REQ-031 host_wr_req and host_rd_req high together: write first, then the read is granted in a separate S_RD after return to S_IDLE.
REQ-032 Acks arriving in a state not expecting them SHALL be ignored.

Reset
REQ-033 rst SHALL asynchronously force S_BOOT_RD, all counters 0, poll_pending 0, time_out 0, time_valid 0, timeout_err 0, host acks 0, drv_wr_req 0, drv_wr_time 0, busy 1; drv_rd_req rises on the first clk edge after release.
REQ-034 rst asserted mid-transaction SHALL abandon it with no host ack pulse.

Verification
REQ-035 Boot, driver returns second=8'h80 -> S_BOOT_WR, drv_wr_time=DEFAULT_TIME with second 8'h01, then one read, time_valid=1.
REQ-036 Boot, driver returns 56'h24_05_06_15_09_30_45 -> no write; time_out equals it, busy low.
REQ-037 POLL_CYCLES=100, idle -> drv_rd_req every 100 cycles; host_rd_ack never pulses.
REQ-038 host_wr_req and host_rd_req same cycle, host_wr_time second=8'hC5 -> write carries 8'h45, host_wr_ack, automatic read, then host read with host_rd_ack.
REQ-039 Driver never acks a read, TIMEOUT_CYCLES=50 -> request dropped after 50 cycles, timeout_err=1, time_out unchanged, S_IDLE.
REQ-040 rst pulse during S_WR -> drv_wr_req low immediately, no host_wr_ack, boot read restarts.
